// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: MDU op codes and default op latencies shared by the ID decoder and the EX-stage MDU
package mdu_unit_pkg;
  typedef enum logic [2:0] {
    MDU_OP_NONE  = 3'd0,
    MDU_OP_MULT  = 3'd1,
    MDU_OP_MULTU = 3'd2,
    MDU_OP_DIV   = 3'd3,
    MDU_OP_DIVU  = 3'd4,
    MDU_OP_MTHI  = 3'd5,
    MDU_OP_MTLO  = 3'd6
  } mdu_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: combinational signed/unsigned divide (in a, b, sgn; out q quotient, r remainder, dz divide-by-zero)
module mdu_div_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        dz
);
  logic        neg_a, neg_b, ovf;
  logic [31:0] mag_a, mag_b, uq, ur;
  assign dz    = b == '0;
  assign neg_a = sgn & a[31];
  assign neg_b = sgn & b[31];
  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;
  assign uq    = dz ? '0 : mag_a / mag_b;
  assign ur    = dz ? '0 : mag_a % mag_b;
  assign ovf   = sgn & (a == 32'h8000_0000) & (b == '1);
  assign q     = ovf ? 32'h8000_0000 : (neg_a ^ neg_b) ? -uq : uq;
  assign r     = ovf ? '0 : neg_a ? -ur : ur;
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multi-cycle MULT/DIV unit owning HI/LO (in clk, reset, start, mdu_op, cancel, a, b; out busy, hi, lo)
import mdu_unit_pkg::*;
module mdu_unit #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  typedef enum logic {IDLE, RUN} state_e;
  state_e         state;
  logic [CW-1:0]  cnt;
  logic [31:0]    res_hi, res_lo, q, r;
  logic [63:0]    sprod, uprod;
  logic           res_ok, go, is_mul, is_div, dz;
  assign busy   = state == RUN;
  assign go     = start & ~cancel & ~busy;
  assign is_mul = mdu_op == MDU_OP_MULT || mdu_op == MDU_OP_MULTU;
  assign is_div = mdu_op == MDU_OP_DIV || mdu_op == MDU_OP_DIVU;
  assign sprod  = 64'($signed(a)) * 64'($signed(b));
  assign uprod  = {32'b0, a} * {32'b0, b};
  mdu_div_core u_div (
    .a(a),
    .b(b),
    .sgn(mdu_op == MDU_OP_DIV),
    .q(q),
    .r(r),
    .dz(dz)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_ok <= 1'b0;
    end else if (state == IDLE) begin
      if (go && is_mul) begin
        state            <= RUN;
        cnt              <= CW'(MULT_CYCLES);
        {res_hi, res_lo} <= mdu_op == MDU_OP_MULT ? sprod : uprod;
        res_ok           <= 1'b1;
      end else if (go && is_div) begin
        state            <= RUN;
        cnt              <= CW'(DIV_CYCLES);
        {res_hi, res_lo} <= {r, q};
        res_ok           <= ~dz;
      end else if (go && mdu_op == MDU_OP_MTHI) begin
        hi <= a;
      end else if (go && mdu_op == MDU_OP_MTLO) begin
        lo <= a;
      end
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= IDLE;
        if (res_ok) {hi, lo} <= {res_hi, res_lo};
      end
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized self-checking bench for mdu_unit against an arithmetic reference model
module tb_mdu_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 0, reset = 1, start = 0, cancel = 0;
  logic [2:0]  mdu_op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy;
  logic [31:0] hi, lo;
  int          checks = 0, failures = 0;
  int          m_left = 0, mlat;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic [63:0] mres;
  bit          p_ok = 0, mok, chk_en = 0;
  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mdu_op(mdu_op),
    .cancel(cancel),
    .a(a),
    .b(b),
    .busy(busy),
    .hi(hi),
    .lo(lo)
  );
  always #5 clk = ~clk;
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [63:0] res, output bit ok, output int lat);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint unsigned ux = {32'b0, x};
    longint unsigned uy = {32'b0, y};
    ok = 1; res = 0; lat = 0;
    case (op)
      3'd1: begin res = sx * sy; lat = MC; end
      3'd2: begin res = ux * uy; lat = MC; end
      3'd3: begin lat = DC; ok = y != 0; if (ok) res = {32'(sx % sy), 32'(sx / sy)}; end
      3'd4: begin lat = DC; ok = y != 0; if (ok) res = {32'(ux % uy), 32'(ux / uy)}; end
      default: ok = 0;
    endcase
  endfunction
  always @(posedge clk) begin
    ref_op(mdu_op, a, b, mres, mok, mlat);
    if (reset) begin
      m_left <= 0; m_hi <= 0; m_lo <= 0; p_ok <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && p_ok) begin m_hi <= p_hi; m_lo <= p_lo; end
    end else if (start && !cancel) begin
      if (mlat > 0) begin
        m_left <= mlat; p_ok <= mok; p_hi <= mres[63:32]; p_lo <= mres[31:0];
      end else if (mdu_op == 3'd5) m_hi <= a;
      else if (mdu_op == 3'd6) m_lo <= a;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", 32'(busy), 32'(m_left > 0));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("start_while_busy", 32'(m_left > 0 && start && !cancel), 0);
      end
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit c, input bit noise, output int n);
    start = 1; mdu_op = op; a = x; b = y; cancel = c;
    @(posedge clk); #1;
    start = 0; cancel = 0; n = 0;
    while (busy && n < 200) begin
      n++;
      if (noise) begin
        cancel = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; mdu_op = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
    end
    cancel = 0;
    if (n >= 200) check("busy_timeout", n, 0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n;
    fork compare_loop(); join_none
    repeat (2) @(posedge clk);
    #1 reset = 0; chk_en = 1;
    check("rst_busy", 32'(busy), 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, n);
    check("mult_cycles", n, MC);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, n);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    issue(3'd3, -32'sd7, 32'd2, 0, 0, n);
    check("div_cycles", n, DC);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd4, 32'd7, 32'd0, 0, 0, n);
    check("divu0_cycles", n, DC);
    check("divu0_hi", hi, 32'hFFFF_FFFF);
    check("divu0_lo", lo, 32'hFFFF_FFFD);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, n);
    check("intmin_lo", lo, 32'h8000_0000);
    check("intmin_hi", hi, 32'h0);
    start = 1; mdu_op = 3'd5; a = 32'h1234;
    @(posedge clk); #1;
    check("mthi_busy", 32'(busy), 0);
    mdu_op = 3'd6; a = 32'h5678;
    @(posedge clk); #1;
    start = 0;
    check("mtlo_busy", 32'(busy), 0);
    check("mt_hi", hi, 32'h1234);
    check("mt_lo", lo, 32'h5678);
    issue(3'd1, 32'd2, 32'd3, 1, 0, n);
    check("cancel_cycles", n, 0);
    check("cancel_hi", hi, 32'h1234);
    check("cancel_lo", lo, 32'h5678);
    issue(3'd1, 32'd2, 32'd3, 0, 0, n);
    check("after_cancel_cycles", n, MC);
    check("after_cancel_hi", hi, 32'h0);
    check("after_cancel_lo", lo, 32'h6);
    start = 1; mdu_op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_busy", 32'(busy), 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_hi", hi, 0);
    check("midrun_rst_lo", lo, 0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, n);
    check("post_rst_cycles", n, MC);
    check("post_rst_hi", hi, 32'hFFFF_FFFF);
    check("post_rst_lo", lo, 32'hFFFF_FFFA);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] x, y;
      x = pick();
      y = pick();
      issue(3'($urandom_range(0, 7)), x, y, $urandom_range(0, 7) == 0, 1, n);
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
